// File: rtl/if_id_fifo.sv
// IF/ID boundary queue: DEPTH-entry circular buffer of {pc, inst} pairs between fetch and decode.
// Valid/ready on both sides; flush drops every queued entry and blocks pushes for that cycle.
module if_id_fifo #(
    parameter int unsigned INST_W = 16,
    parameter int unsigned PC_W   = 16,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_50MHz,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_bad_depth
        $error("if_id_fifo: DEPTH must be a power of two in 2..16");
    end

    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [INST_W-1:0] inst_mem_d [DEPTH];
    logic [PC_W-1:0]   pc_mem_q   [DEPTH];
    logic [PC_W-1:0]   pc_mem_d   [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // A full queue never accepts, even if decode pops in the same cycle.
    assign in_ready  = ~full & ~flush;
    assign out_valid = ~empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready & ~flush;
    assign count     = count_q;

    assign out_inst = empty ? '0 : inst_mem_q[rd_ptr_q];
    assign out_pc   = empty ? '0 : pc_mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;
        if (push) begin
            inst_mem_d[wr_ptr_q] = in_inst;
            pc_mem_d[wr_ptr_q]   = in_pc;
        end
    end

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; occupancy alone decides what is visible.
    always_ff @(posedge clk_50MHz) begin
        inst_mem_q <= inst_mem_d;
        pc_mem_q   <= pc_mem_d;
    end

endmodule

// File: doc/if_id_fifo.md
Name: if_id_fifo

Overview:
Parametrised IF/ID boundary buffer. It replaces the single IF/ID pipeline register with a DEPTH-entry queue of {PC, instruction} pairs.
- Fetch pushes with a valid/ready handshake; decode pops the same way.
- Pause becomes backpressure, and clear becomes a flush of every queued entry.
- While decode stalls, fetch keeps running until the queue is full.

Parameters:
INST_W, 16, instruction width in bits.
PC_W, 16, PC width in bits.
DEPTH, 4, number of queued entries; power of two, legal range 2..16.
CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived).

Ports:
clk_50MHz  in  1  system clock, all state updates on its rising edge.
rst  in  1  asynchronous reset, active-low.
in_valid  in  1  fetch presents an entry this cycle.
in_ready  out  1  queue can accept an entry this cycle.
in_inst  in  INST_W  fetched instruction.
in_pc  in  PC_W  PC+1 value associated with in_inst.
flush  in  1  branch/jump redirect; discard all entries.
out_valid  out  1  head entry present.
out_ready  in  1  decode consumes the head this cycle.
out_inst  out  INST_W  head instruction; zero when out_valid=0.
out_pc  out  PC_W  head PC value; zero when out_valid=0.
count  out  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
Storage
- Circular buffer of DEPTH entries.
- Read and write pointers are log2(DEPTH) bits and wrap naturally.
- Occupancy is a separate counter.

Handshake
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- in_ready = (count != DEPTH) & ~flush. It is combinational from registered state plus flush.
- A full queue refuses a push even when a pop occurs in the same cycle. This is a deliberate no full-bypass rule.
- out_valid = (count != 0). It is registered state only.

Output data
- out_inst and out_pc are read combinationally from the head entry.
- Both are forced to zero (instruction all-zero = NOP) when count==0.

Latency
- An entry pushed at edge N is visible on out_* after edge N, i.e. one cycle.
- There is no same-cycle pass-through when the queue is empty.

Counter update per edge
- push only: count+1.
- pop only: count-1.
- push and pop together: count unchanged, both pointers advance.
- Neither: all state holds.

Flush
- flush=1 at an edge: count<=0, rd_ptr<=0, wr_ptr<=0.
- Any simultaneous in_valid or out_ready is ignored, and no entry is retained.
- out_valid=0 and out_inst=0 from the next cycle.
- in_ready is low during the flush cycle and returns high on the following cycle.

Boundary rules
- Empty with out_ready=1: no pop, count stays 0.
- Full with in_valid=1: no push; in_inst is not written and the entry at wr_ptr is preserved.
- Pointer wrap from DEPTH-1 to 0 is transparent to data ordering.
- Strict FIFO order is maintained across all wraps.

Reset
- rst=0 asynchronously clears count, rd_ptr and wr_ptr.
- Outputs go to: out_valid=0, out_inst=0, out_pc=0, count=0, in_ready=1.
- Storage array contents are not reset.
- Reset mid-operation discards all entries.
- The first push after rst rises lands in slot 0.

Test Plan:
- Reset then fill, DEPTH=4: push pc=1..4, inst=0xA001..0xA004 with out_ready=0 -> count=4, in_ready=0 after 4th edge; out_inst=0xA001, out_pc=1 throughout.
- Drain order: from the full state, out_ready=1 for 4 cycles -> out_inst sequence 0xA001..0xA004; then out_valid=0, out_inst=0x0000, count=0.
- Simultaneous push/pop at count=2 for 10 cycles -> count stays 2; output order matches input order across pointer wrap; no loss or duplication.
- Full refusal: count=4, in_valid=1, in_inst=0xBEEF, out_ready=1 for one cycle -> count=3; 0xBEEF never appears at the output.
- Flush with simultaneous push and pop at count=3 -> next cycle count=0, out_valid=0, out_inst=0; in_ready=0 during flush and 1 the following cycle.
- Async reset asserted mid-cycle at count=2 -> outputs clear immediately, without waiting for a clock edge; after release, push pc=0x0010 -> out_pc=0x0010 one cycle later, count=1.
